// File: rtl/arbiter_pkg.sv
// Shared constants and helpers for the four-way arbiter leaves.
package arbiter_pkg;

    localparam int N_PORTS = 4;
    localparam int ID_W    = 2;

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx);
        return idx + 1'b1;   // wraps mod N_PORTS because ID_W = log2(N_PORTS)
    endfunction

endpackage

// File: rtl/arb4_wrr_pick.sv
// Rotating-priority picker: first set candidate at or after ptr, wrapping.
module arb4_wrr_pick
    import arbiter_pkg::*;
(
    input  logic [N_PORTS-1:0] cand,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    g,
    output logic [N_PORTS-1:0] onehot
);

    logic [ID_W-1:0] idx;

    always_comb begin
        any = 1'b0;
        g   = ptr;
        idx = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = ptr + ID_W'(k);
            if (!any && cand[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
        onehot = any ? (N_PORTS'(1) << g) : '0;
    end

endmodule

// File: rtl/arbiter4_wrr_pipeline.sv
// Four-requester weighted round-robin arbiter with one registered output stage.
// Optional ARB_ID_EN adds a registered id_out carrying the granted port index.
//
//   state | meaning
//   ptr   | port currently holding top priority
//   used  | consecutive grants already taken by ptr (cleared on rotation)
module arbiter4_wrr_pipeline
    import arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WW    = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS-1:0]       valid_in,
    input  logic [N_PORTS*WIDTH-1:0] data_in,
    output logic [N_PORTS-1:0]       ready_out,
    output logic                     valid_out,
    output logic [WIDTH-1:0]         data_out,
    input  logic                     ready_in,
    input  logic [N_PORTS*WW-1:0]    weight_in,
    input  logic                     weight_load
`ifdef ARB_ID_EN
    ,
    output logic [ID_W-1:0]          id_out
`endif
);

    logic [WW-1:0]      weight [N_PORTS];
    logic [N_PORTS-1:0] cand;
    logic               any;
    logic [ID_W-1:0]    g;
    logic [N_PORTS-1:0] onehot;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [WW-1:0]      used, used_nxt, used_inc;
    logic               slot_free;
    logic               grant;

    always_comb begin
        cand = '0;
        for (int i = 0; i < N_PORTS; i++)
            cand[i] = valid_in[i] & (weight[i] != '0);
    end

    arb4_wrr_pick u_pick (
        .cand   (cand),
        .ptr    (ptr),
        .any    (any),
        .g      (g),
        .onehot (onehot)
    );

    assign slot_free = !valid_out | ready_in;
    assign grant     = !rst & slot_free & any;
    assign ready_out = grant ? onehot : '0;

    // Lowering a weight below used still rotates on the next grant via >=.
    always_comb begin
        ptr_nxt  = ptr;
        used_nxt = used;
        used_inc = (g == ptr) ? used + 1'b1 : WW'(1);
        if (grant) begin
            if (used_inc >= weight[g]) begin
                ptr_nxt  = rr_next(g);
                used_nxt = '0;
            end else begin
                ptr_nxt  = g;
                used_nxt = used_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            used <= '0;
        end else begin
            ptr  <= ptr_nxt;
            used <= used_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PORTS; i++)
                weight[i] <= WW'(1);
        end else if (weight_load) begin
            for (int i = 0; i < N_PORTS; i++)
                weight[i] <= weight_in[i*WW +: WW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (grant) begin
            valid_out <= 1'b1;
            data_out  <= data_in[g*WIDTH +: WIDTH];
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

`ifdef ARB_ID_EN
    always_ff @(posedge clk) begin
        if (rst)
            id_out <= '0;
        else if (grant)
            id_out <= g;
    end
`endif

endmodule

// File: tb/tb_arbiter4_wrr_pipeline.sv
// Randomized scoreboard bench for arbiter4_wrr_pipeline against a WRR reference model.
module tb_arbiter4_wrr_pipeline;

    localparam int WIDTH = 4;
    localparam int WW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        valid_in;
    logic [4*WIDTH-1:0] data_in;
    logic [3:0]        ready_out;
    logic              valid_out;
    logic [WIDTH-1:0]  data_out;
    logic              ready_in;
    logic [4*WW-1:0]   weight_in;
    logic              weight_load;
`ifdef ARB_ID_EN
    logic [1:0]        id_out;
`endif

    int checks = 0;
    int errors = 0;

    arbiter4_wrr_pipeline #(.WIDTH(WIDTH), .WW(WW)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .ready_in    (ready_in),
        .weight_in   (weight_in),
        .weight_load (weight_load)
`ifdef ARB_ID_EN
        ,
        .id_out      (id_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int data; int id; } item_t;
    item_t sb_q[$];

    // Reference model state, in spec terms
    int m_ptr = 0;
    int m_used = 0;
    int m_w [4] = '{1, 1, 1, 1};
    bit m_valid = 0;
    bit prev_rst = 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: evaluates each cycle's handshake just before the rising edge
    always @(negedge clk) begin
        int g;
        int exp_ro;
        int cnt;
        bit slot;
        if (prev_rst) check("data_after_reset", int'(data_out), 0);
        check("valid_out", int'(valid_out), int'(m_valid));
        if (rst) begin
            check("ready_out_in_reset", int'(ready_out), 0);
            m_ptr = 0; m_used = 0; m_valid = 0;
            for (int i = 0; i < 4; i++) m_w[i] = 1;
            sb_q.delete();
        end else begin
            slot = !m_valid || ready_in;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                int p;
                p = (m_ptr + k) % 4;
                if (g < 0 && valid_in[p] && m_w[p] != 0) g = p;
            end
            exp_ro = (slot && g >= 0) ? (1 << g) : 0;
            check("ready_out", int'(ready_out), exp_ro);
            if (exp_ro != 0) begin
                item_t it;
                it.data = int'(data_in[g*WIDTH +: WIDTH]);
                it.id   = g;
                sb_q.push_back(it);
                cnt = (g == m_ptr) ? m_used + 1 : 1;
                if (cnt >= m_w[g]) begin
                    m_ptr = (g + 1) % 4;
                    m_used = 0;
                end else begin
                    m_ptr = g;
                    m_used = cnt;
                end
                m_valid = 1;
            end else if (ready_in) begin
                m_valid = 0;
            end
            if (weight_load)
                for (int i = 0; i < 4; i++) m_w[i] = int'(weight_in[i*WW +: WW]);
        end
        prev_rst = rst;
    end

    // Monitor: compares whatever the output register presents
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: actual data %0d required none at %0t", data_out, $time);
            end else begin
                check("data_out", int'(data_out), sb_q[0].data);
`ifdef ARB_ID_EN
                check("id_out", int'(id_out), sb_q[0].id);
`endif
                if (ready_in) void'(sb_q.pop_front());
            end
        end
    end

    task automatic step(input logic [3:0] vi, input logic ri, input int n);
        valid_in = vi;
        ready_in = ri;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_w(input logic [15:0] w);
        weight_in   = w;
        weight_load = 1'b1;
        @(posedge clk);
        #1;
        weight_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 4'h0; data_in = 16'h4321; ready_in = 1'b1;
        weight_in = 16'h1111; weight_load = 1'b0;
        step(4'h0, 1'b1, 2);
        rst = 1'b0;
        step(4'hf, 1'b1, 12);          // plain round robin 1,2,3,4,...
        load_w(16'h1113);              // port 0 weight 3
        step(4'hf, 1'b1, 14);
        step(4'hf, 1'b0, 5);           // backpressure
        step(4'hf, 1'b1, 8);
        load_w(16'h1111);
        step(4'h4, 1'b1, 6);           // single requester
        step(4'h0, 1'b1, 3);
        load_w(16'h1101);              // port 1 masked
        step(4'hf, 1'b1, 10);
        step(4'hf, 1'b0, 2);
        rst = 1'b1;                    // reset with data held in register
        step(4'hf, 1'b0, 1);
        rst = 1'b0;
        step(4'hf, 1'b1, 8);
        load_w(16'h0000);              // everything masked
        step(4'hf, 1'b1, 3);
        load_w(16'h2f13);
        step(4'hf, 1'b1, 30);
        load_w(16'h1111);              // lower weights mid-run
        step(4'hf, 1'b1, 6);

        for (int c = 0; c < 600; c++) begin
            data_in     = 16'($urandom);
            valid_in    = 4'($urandom);
            ready_in    = ($urandom_range(0, 3) != 0);
            weight_load = ($urandom_range(0, 19) == 0);
            weight_in   = 16'($urandom);
            rst         = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; weight_load = 1'b0;
        step(4'h0, 1'b1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter4_wrr_pipeline.md
Name: arbiter4_wrr_pipeline

Overview:
Four-requester weighted round-robin (WRR) arbiter with a single registered output stage. Each requester has a valid/ready input channel; the arbiter drives one valid/ready output channel. Per-port weights are runtime-loadable and set how many consecutive grants a port may take before priority rotates. It is the drop-in weighted successor to the plain four-way pipelined arbiter and a leaf of the 32-way arbitration tree.

Parameters:
WIDTH, 4, data width per requester and of data_out
WW, 4, weight width per port (weights 0..2^WW-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
valid_in  in  4  per-port request valid
data_in  in  4*WIDTH  port i data at [i*WIDTH +: WIDTH]
ready_out  out  4  per-port accept; a port's transfer occurs when valid_in[i] & ready_out[i]
valid_out  out  1  output register holds valid data
data_out  out  WIDTH  output register data
ready_in  in  1  downstream accept; drain occurs when valid_out & ready_in
weight_in  in  4*WW  port i weight at [i*WW +: WW]
weight_load  in  1  latch weight_in into weight registers on this edge

Behaviour:
- Reset (clk edge with rst=1): valid_out=0, data_out=0, ready_out=0000 during reset, ptr=0, used=0, all weights=1 (plain round robin).
- slot_free = !valid_out | ready_in (combinational).
- Candidates: valid_in[i] & (weight[i]!=0). g = first candidate searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- ready_out = one-hot(g) when slot_free and any candidate exists, else 0000. ready_out never has more than one bit set. ready_out depends combinationally on valid_in, weights and ready_in.
- Latency: one cycle. The granted data appears on data_out with valid_out=1 on the edge after the transfer.
- On grant: used_next = (g==ptr) ? used+1 : 1.
  - If used_next >= weight[g]: ptr <= g+1 mod 4, used <= 0.
  - Else: ptr <= g, used <= used_next.
- No grant this cycle (no candidate, or !slot_free): ptr and used hold. If the register was drained with no new grant, valid_out <= 0 and data_out holds its last value.
- Backpressure (valid_out & !ready_in): data_out/valid_out hold, ready_out=0000. Back-to-back throughput is one transfer per cycle while ready_in=1.
- weight_load: new weights apply from the next cycle. A same-cycle grant uses the old weights. If a weight is lowered below used, the >= compare rotates ptr at that port's next grant.
- A weight of 0 masks the port: ready_out[i] is never asserted. If all valid ports are masked, nothing is granted.
- used is WW bits wide and cannot overflow, because it is cleared whenever it reaches the weight.
- Reset mid-operation: any in-flight output data is discarded, valid_out=0 the next cycle, weights return to 1.

Optional Feature:
ARB_ID_EN
- Defined: adds output port id_out [1:0], registered alongside data_out and loaded with g on each grant. Reset value is 0; it holds under backpressure.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package arbiter_pkg:
  - N_PORTS=4
  - ID_W=2
  - function rr_next(idx) returning (idx+1) mod N_PORTS
- Sub-module arb4_wrr_pick: combinational rotating-priority picker.
  - Inputs: candidate mask [3:0], ptr [1:0].
  - Outputs: any, g [1:0], onehot [3:0].
- The top level holds the weight registers, ptr/used FSM and output register.

Test Plan:
- Default weights, WIDTH=4, valid_in=1111, data_in=16'h4321, ready_in=1, rst released after one cycle -> data_out sequence 1,2,3,4,1,2,... one per cycle, valid_out=1 continuously from the first edge after the first grant.
- weight_load with weights {p3..p0}={1,1,1,3}, valid_in=1111, data_in=16'h4321 -> data_out 1,1,1,2,3,4,1,1,1,...
- Mid-stream ready_in=0 for 5 cycles -> data_out and valid_out frozen, ready_out=0000, ptr/used frozen; sequence resumes with no loss or duplication when ready_in returns to 1.
- valid_in=0100 only, weights all 1 -> port 2 granted every cycle, data_out=3 continuously. Then valid_in=0000 -> valid_out drops to 0 one cycle later.
- Weight of port 1 set to 0, valid_in=1111 -> data_out 1,3,4,1,3,4; ready_out[1] never asserts.
- rst=1 asserted while streaming -> next cycle valid_out=0, data_out=0, weights=1; after release the sequence restarts at port 0.
